logic_unit_arbiter: RTL and testbench

Sequencer and arbiter that shares a single WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) between NREQ requesters. Each requester offers an opcode and two operands over a valid/ready handshake. The block grants one requester at a time, registers its operands, and executes the operation in one cycle. It then returns the result, tagged with the requester index, over a valid/ready response channel. It sits between the step-2 binary logic gates and the upstream control that issues logic operations.

---
 rtl/logic_unit_arbiter.sv | 170 +++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Arbitrated single-cycle bitwise logic unit (AND/OR/XOR/NOT) shared by NREQ requesters.
// Define LOGIC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module logic_unit_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] alu_out;

`ifdef LOGIC_ARB_RR_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  // Winner selection: round-robin search from the pointer, or lowest index first.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
`ifdef LOGIC_ARB_RR_EN
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ_U) idx = idx - NREQ_U;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
`else
    for (int unsigned k = NREQ_U; k > 0; k--) begin
      idx = k - 1;
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
`endif
  end

  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    grant  = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (IDW'(i) == win_id) begin
        win_op = req_op[2*i +: 2];
        win_a  = req_a[WIDTH*i +: WIDTH];
        win_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
    if (win_found) grant[win_id] = 1'b1;
  end

  always_comb begin
    case (op_q)
      2'b00:   alu_out = a_q & b_q;
      2'b01:   alu_out = a_q | b_q;
      2'b10:   alu_out = a_q ^ b_q;
      default: alu_out = ~a_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef LOGIC_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          op_d    = win_op;
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_id;
          state_d = S_EXEC;
`ifdef LOGIC_ARB_RR_EN
          ptr_d   = (win_id == IDW'(NREQ_U - 1)) ? '0 : win_id + 1'b1;
`endif
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        zero_d   = (alu_out == '0);
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef LOGIC_ARB_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef LOGIC_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE) ? grant : '0;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: transaction-level model predicts grants and results.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  busy;

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  int checks   = 0;
  int failures = 0;
  int exp_id_q[$];
  int exp_res_q[$];
  bit hold_mode = 0;
  bit rand_mode = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]        = op_arr[i];
      req_a[WIDTH*i +: WIDTH] = a_arr[i];
      req_b[WIDTH*i +: WIDTH] = b_arr[i];
    end
  end

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_op(input int op, input int a, input int b);
    int mask = (1 << WIDTH) - 1;
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (~a) & mask;
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
`ifdef LOGIC_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  // Model: phase 0 idle, 1 executing, 2 responding.
  int               m_phase = 0;
  int               m_ptr   = 0;
  bit               held_v  = 0;
  logic [IDW-1:0]   held_id;
  logic [WIDTH-1:0] held_res;
  logic             held_zero;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    int w, eid, eres;
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      held_v  = 0;
      exp_id_q.delete();
      exp_res_q.delete();
    end else begin
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      exp_ready = '0;
      w = -1;
      if (m_phase == 0 && |req_valid) begin
        w = pick(req_valid, m_ptr);
        exp_ready[w] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (held_v) begin
        chk("hold_id", 32'(rsp_id), 32'(held_id));
        chk("hold_result", 32'(rsp_result), 32'(held_res));
        chk("hold_zero", 32'(rsp_zero), 32'(held_zero));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id_q.size() == 0) begin
          chk("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          eid  = exp_id_q.pop_front();
          eres = exp_res_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(eid));
          chk("rsp_result", 32'(rsp_result), 32'(eres));
          chk("rsp_zero", 32'(rsp_zero), 32'(eres == 0));
        end
      end
      held_v    = rsp_valid && !rsp_ready;
      held_id   = rsp_id;
      held_res  = rsp_result;
      held_zero = rsp_zero;
      case (m_phase)
        0: if (w >= 0) begin
          exp_id_q.push_back(w);
          exp_res_q.push_back(model_op(int'(op_arr[w]), int'(a_arr[w]), int'(b_arr[w])));
          m_ptr   = (w + 1) % NREQ;
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic set_req(input int i, input int op, input int a, input int b);
    op_arr[i]    = 2'(op);
    a_arr[i]     = WIDTH'(a);
    b_arr[i]     = WIDTH'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic rand_req(input int i);
    set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  // One clock: sample grants before the edge, update requesters just after it.
  task automatic step(output logic [NREQ-1:0] acc);
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (hold_mode) rand_req(i);
        else req_valid[i] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic issue(input int i, input int op, input int a, input int b);
    logic [NREQ-1:0] acc;
    bit got = 0;
    set_req(i, op, a, b);
    for (int n = 0; n < 20 && !got; n++) begin
      step(acc);
      got = acc[i];
    end
    if (!got) chk("grant_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input int limit);
    logic [NREQ-1:0] acc;
    bit done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      step(acc);
      done = !busy && (req_valid == '0);
    end
    if (!done) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0;
    end
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(rsp_id), 32'(0));
    chk("rst_rsp_result", 32'(rsp_result), 32'(0));
    chk("rst_rsp_zero", 32'(rsp_zero), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(0, 0, 4'b0001, 4'b0101); wait_idle(20);
    issue(2, 0, 4'b1111, 4'b1101); wait_idle(20);
    issue(2, 2, 4'b1010, 4'b1010); wait_idle(20);
    issue(1, 1, 4'b0011, 4'b0101); wait_idle(20);
    issue(1, 3, 4'b0110, 4'b1111); wait_idle(20);

    // Backpressure with another requester waiting behind the response.
    rsp_ready = 1'b0;
    issue(0, 2, 4'b1100, 4'b0110);
    set_req(3, 1, 4'b1000, 4'b0001);
    repeat (6) step(acc);
    rsp_ready = 1'b1;
    wait_idle(20);

    // All requesters continuously valid.
    for (int i = 0; i < NREQ; i++) rand_req(i);
    hold_mode = 1;
    repeat (16) step(acc);
    hold_mode = 0;
    wait_idle(30);

    // Reset while executing; pointer left non-zero beforehand.
    issue(1, 0, 4'b1011, 4'b0110); wait_idle(20);
    issue(3, 1, 4'b0101, 4'b0010);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'(0));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("midrst_rsp_id", 32'(rsp_id), 32'(0));
    chk("midrst_rsp_result", 32'(rsp_result), 32'(0));
    chk("midrst_rsp_zero", 32'(rsp_zero), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    hold_mode = 1;
    repeat (7) step(acc);
    hold_mode = 0;
    wait_idle(30);

    rand_mode = 1;
    repeat (300) step(acc);
    rand_mode = 0;
    rsp_ready = 1'b1;
    wait_idle(60);
    repeat (2) step(acc);
    chk("scoreboard_drain", 32'(exp_id_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
